stg_wb_q: RTL and testbench

Parametrised successor to the single-cycle writeback stage: a queued GP writeback stage with a DEPTH-entry retire FIFO draining up to NPORTS register-file writes per cycle. Sits between MEM/EX result latch and the GP register file.
Provides youngest-first forwarding of pending writes to the decode/hazard logic. Holds trap signalling until all older writes have committed.
PC/opcode side-band is latched and advances only on accepted retires.

---
 rtl/stg_wb_q_pkg.sv | 16 +
 rtl/stg_wb_q_if.sv | 32 +++
 rtl/stg_wb_q_fwd_match.sv | 29 ++
 rtl/stg_wb_q.sv | 191 +++++++++++++++++++
 tb/tb_stg_wb_q.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stg_wb_q_pkg.sv
// Shared sizes and types for the queued GP writeback stage.
// SIZE_* give the default widths of GP data, PC, opcode and GP target address.
// trap_st_e tracks whether a trap retire is waiting for older writes to commit.
package stg_wb_q_pkg;

  localparam int unsigned SIZE_DATA   = 24;
  localparam int unsigned SIZE_ADDR   = 48;
  localparam int unsigned SIZE_OPC    = 8;
  localparam int unsigned SIZE_TGT_GP = 4;

  typedef enum logic [0:0] {
    StRun,
    StTrapWait
  } trap_st_e;

endpackage

// File: rtl/stg_wb_q_if.sv
// Retire handshake bus from the MEM/EX result latch into the writeback queue.
// master: drives the retiring instruction (valid, pc, opc, GP target/data, trap), sees ready.
// slave:  the writeback queue; samples the retire and returns ready.
interface stg_wb_q_if
  import stg_wb_q_pkg::*;
#(
  parameter int unsigned DATA_W = SIZE_DATA,
  parameter int unsigned ADDR_W = SIZE_ADDR,
  parameter int unsigned OPC_W  = SIZE_OPC,
  parameter int unsigned TGT_W  = SIZE_TGT_GP
);

  logic              iw_valid;
  logic [ADDR_W-1:0] iw_pc;
  logic [OPC_W-1:0]  iw_opc;
  logic              iw_tgt_gp_we;
  logic [TGT_W-1:0]  iw_tgt_gp;
  logic [DATA_W-1:0] iw_result;
  logic              iw_trap_pending;
  logic              ow_ready;

  modport master (
    output iw_valid, iw_pc, iw_opc, iw_tgt_gp_we, iw_tgt_gp, iw_result, iw_trap_pending,
    input  ow_ready
  );

  modport slave (
    input  iw_valid, iw_pc, iw_opc, iw_tgt_gp_we, iw_tgt_gp, iw_result, iw_trap_pending,
    output ow_ready
  );

endinterface

// File: rtl/stg_wb_q_fwd_match.sv
// Youngest-first priority matcher over N age-ordered entries (index 0 = oldest).
// valid/addr/data: per-entry state; lookup: address to search.
// hit: some valid entry matches; hit_data: data of the youngest match, 0 on miss.
module stg_wb_q_fwd_match #(
  parameter int unsigned N      = 4,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 24
) (
  input  logic [N-1:0]             valid,
  input  logic [N-1:0][ADDR_W-1:0] addr,
  input  logic [N-1:0][DATA_W-1:0] data,
  input  logic [ADDR_W-1:0]        lookup,
  output logic                     hit,
  output logic [DATA_W-1:0]        hit_data
);

  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    // Ascending scan: a younger match overwrites any older one.
    for (int i = 0; i < int'(N); i++) begin
      if (valid[i] && (addr[i] == lookup)) begin
        hit      = 1'b1;
        hit_data = data[i];
      end
    end
  end

endmodule

// File: rtl/stg_wb_q.sv
// Queued GP writeback stage: DEPTH-entry retire FIFO draining up to NPORTS
// register-file writes per cycle, with youngest-first forwarding and trap ordering.
// Ports:
//   iw_clk, iw_rst      clock, asynchronous active-high reset
//   rb                  retire handshake (slave side)
//   iw_rf_stall         register file ports unavailable this cycle
//   ow_gp_write_*       per-port write strobe / address / data
//   iw_fwd_addr         forwarding lookup; ow_fwd_hit/ow_fwd_data result
//   ow_pc, ow_opc       side-band of the last accepted retire
//   ow_count            occupied FIFO entries
//   ow_trap_pending     one-cycle trap pulse, after all older writes commit
module stg_wb_q
  import stg_wb_q_pkg::*;
#(
  parameter int unsigned DATA_W = SIZE_DATA,
  parameter int unsigned ADDR_W = SIZE_ADDR,
  parameter int unsigned OPC_W  = SIZE_OPC,
  parameter int unsigned TGT_W  = SIZE_TGT_GP,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned NPORTS = 2
) (
  input  logic                     iw_clk,
  input  logic                     iw_rst,
  stg_wb_q_if.slave                rb,
  input  logic                     iw_rf_stall,
  output logic [NPORTS-1:0]        ow_gp_write_enable,
  output logic [NPORTS*TGT_W-1:0]  ow_gp_write_addr,
  output logic [NPORTS*DATA_W-1:0] ow_gp_write_data,
  input  logic [TGT_W-1:0]         iw_fwd_addr,
  output logic                     ow_fwd_hit,
  output logic [DATA_W-1:0]        ow_fwd_data,
  output logic [ADDR_W-1:0]        ow_pc,
  output logic [OPC_W-1:0]         ow_opc,
  output logic [$clog2(DEPTH):0]   ow_count,
  output logic                     ow_trap_pending
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][TGT_W-1:0]  addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [PTR_W-1:0]             head_q, tail_q;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [ADDR_W-1:0]            pc_q;
  logic [OPC_W-1:0]             opc_q;
  trap_st_e                     state_q, state_d;
  logic                         trap_q, trap_d;

  logic [CNT_W-1:0] drain;
  logic             ready;
  logic             accept;
  logic             enq;

  // Entries viewed in age order: index 0 is the head (oldest).
  logic [DEPTH-1:0]             age_valid;
  logic [DEPTH-1:0][TGT_W-1:0]  age_addr;
  logic [DEPTH-1:0][DATA_W-1:0] age_data;

  assign drain   = iw_rf_stall ? '0 :
                   ((count_q < CNT_W'(NPORTS)) ? count_q : CNT_W'(NPORTS));
  // A full queue still accepts when the same cycle frees a slot.
  assign ready   = (state_q == StRun) && ((count_q - drain) < CNT_W'(DEPTH));
  assign accept  = rb.iw_valid && ready;
  assign enq     = accept && rb.iw_tgt_gp_we;
  assign count_d = count_q + CNT_W'(enq) - drain;

  always_comb begin
    age_valid = '0;
    age_addr  = '0;
    age_data  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      age_valid[i] = CNT_W'(i) < count_q;
      age_addr[i]  = addr_q[PTR_W'(head_q + PTR_W'(i))];
      age_data[i]  = data_q[PTR_W'(head_q + PTR_W'(i))];
    end
  end

  // Draining entries still forward: the register file updates on the same edge.
  stg_wb_q_fwd_match #(
    .N      (DEPTH),
    .ADDR_W (TGT_W),
    .DATA_W (DATA_W)
  ) u_fwd (
    .valid    (age_valid),
    .addr     (age_addr),
    .data     (age_data),
    .lookup   (iw_fwd_addr),
    .hit      (ow_fwd_hit),
    .hit_data (ow_fwd_data)
  );

  // Port k writes age entry k unless a younger draining entry targets the same register.
  // The matcher returns the age index of the youngest draining match at or after k.
  for (genvar k = 0; k < int'(NPORTS); k++) begin : g_port
    logic [DEPTH-1:0]            mask;
    logic [DEPTH-1:0][PTR_W-1:0] ages;
    logic                        hit;
    logic [PTR_W-1:0]            idx;

    always_comb begin
      mask = '0;
      ages = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mask[i] = (i >= k) && (CNT_W'(i) < drain);
        ages[i] = PTR_W'(i);
      end
    end

    stg_wb_q_fwd_match #(
      .N      (DEPTH),
      .ADDR_W (TGT_W),
      .DATA_W (PTR_W)
    ) u_sup (
      .valid    (mask),
      .addr     (age_addr),
      .data     (ages),
      .lookup   (age_addr[k]),
      .hit      (hit),
      .hit_data (idx)
    );

    assign ow_gp_write_enable[k]                = hit && (idx == PTR_W'(k));
    assign ow_gp_write_addr[k*TGT_W +: TGT_W]   = hit ? age_addr[k] : '0;
    assign ow_gp_write_data[k*DATA_W +: DATA_W] = hit ? age_data[k] : '0;
  end

  // Trap FSM: the pulse is registered off the post-edge occupancy, so it lands in the
  // cycle right after the last older write has reached the register file.
  always_comb begin
    state_d = state_q;
    trap_d  = 1'b0;
    case (state_q)
      StRun: begin
        if (accept && rb.iw_trap_pending) begin
          if (count_d == '0) begin
            trap_d = 1'b1;
          end else begin
            state_d = StTrapWait;
          end
        end
      end
      StTrapWait: begin
        if (count_d == '0) begin
          state_d = StRun;
          trap_d  = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state_q <= StRun;
      trap_q  <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pc_q    <= '0;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      trap_q  <= trap_d;
      head_q  <= head_q + PTR_W'(drain);
      count_q <= count_d;
      if (enq) begin
        tail_q <= tail_q + PTR_W'(1);
      end
      if (accept) begin
        pc_q  <= rb.iw_pc;
        opc_q <= rb.iw_opc;
      end
    end
  end

  // Payload storage needs no reset; occupancy alone qualifies it.
  always_ff @(posedge iw_clk) begin
    if (enq) begin
      addr_q[tail_q] <= rb.iw_tgt_gp;
      data_q[tail_q] <= rb.iw_result;
    end
  end

  assign rb.ow_ready      = ready;
  assign ow_pc            = pc_q;
  assign ow_opc           = opc_q;
  assign ow_count         = count_q;
  assign ow_trap_pending  = trap_q;

endmodule

// File: tb/tb_stg_wb_q.sv
module tb_stg_wb_q;
  import stg_wb_q_pkg::*;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned ADDR_W = 48;
  localparam int unsigned OPC_W  = 8;
  localparam int unsigned TGT_W  = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned NPORTS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                     rf_stall;
  logic [NPORTS-1:0]        wr_en;
  logic [NPORTS*TGT_W-1:0]  wr_addr;
  logic [NPORTS*DATA_W-1:0] wr_data;
  logic [TGT_W-1:0]         fwd_addr;
  logic                     fwd_hit;
  logic [DATA_W-1:0]        fwd_data;
  logic [ADDR_W-1:0]        pc;
  logic [OPC_W-1:0]         opc;
  logic [$clog2(DEPTH):0]   count;
  logic                     trap;

  stg_wb_q_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W), .TGT_W(TGT_W)) rb ();

  stg_wb_q #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .OPC_W  (OPC_W),
    .TGT_W  (TGT_W),
    .DEPTH  (DEPTH),
    .NPORTS (NPORTS)
  ) dut (
    .iw_clk             (clk),
    .iw_rst             (rst),
    .rb                 (rb),
    .iw_rf_stall        (rf_stall),
    .ow_gp_write_enable (wr_en),
    .ow_gp_write_addr   (wr_addr),
    .ow_gp_write_data   (wr_data),
    .iw_fwd_addr        (fwd_addr),
    .ow_fwd_hit         (fwd_hit),
    .ow_fwd_data        (fwd_data),
    .ow_pc              (pc),
    .ow_opc             (opc),
    .ow_count           (count),
    .ow_trap_pending    (trap)
  );

  typedef struct packed {
    logic [TGT_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  tests = 0;
  int  fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [TGT_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [TGT_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic we, input logic tr, input logic [ADDR_W-1:0] p,
                       input logic [OPC_W-1:0] o);
    rb.iw_valid        = v;
    rb.iw_tgt_gp       = a;
    rb.iw_result       = d;
    rb.iw_tgt_gp_we    = we;
    rb.iw_trap_pending = tr;
    rb.iw_pc           = p;
    rb.iw_opc          = o;
  endtask

  task automatic idle();
    rb.iw_valid        = 1'b0;
    rb.iw_tgt_gp_we    = 1'b0;
    rb.iw_trap_pending = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (count != '0 && n < 10) begin
      step();
      @(negedge clk);
      n++;
    end
    chk(name, 64'(count), 64'd0);
  endtask

  // Write-port monitor: every strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    for (int k = 0; k < int'(NPORTS); k++) begin
      if (wr_en[k]) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: port %0d wrote R%0d=0x%0h, required no write",
                   k, wr_addr[k*TGT_W +: TGT_W], wr_data[k*DATA_W +: DATA_W]);
        end else begin
          mon_e = exp_q.pop_front();
          chk("write_addr", 64'(wr_addr[k*TGT_W +: TGT_W]), 64'(mon_e.addr));
          chk("write_data", 64'(wr_data[k*DATA_W +: DATA_W]), 64'(mon_e.data));
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    // Reset held with a retire presented: nothing may be written or counted.
    rf_stall = 1'b0;
    fwd_addr = TGT_W'(3);
    drive(1'b1, TGT_W'(3), 24'h00ABCD, 1'b1, 1'b0, 48'h100, 8'h11);
    repeat (3) @(negedge clk);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_we", 64'(wr_en), 64'd0);
    chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
    chk("rst_fwd_data", 64'(fwd_data), 64'd0);
    chk("rst_pc", 64'(pc), 64'd0);
    chk("rst_opc", 64'(opc), 64'd0);
    chk("rst_trap", 64'(trap), 64'd0);

    step();
    rst = 1'b0;
    expect_wr(TGT_W'(3), 24'h00ABCD);
    @(negedge clk);
    chk("post_rst_ready", 64'(rb.ow_ready), 64'd1);
    step();
    idle();
    @(negedge clk);
    chk("first_count", 64'(count), 64'd1);
    chk("first_pc", 64'(pc), 64'h100);
    chk("first_opc", 64'(opc), 64'h11);
    chk("first_fwd_hit", 64'(fwd_hit), 64'd1);
    chk("first_fwd_data", 64'(fwd_data), 64'h00ABCD);
    step();
    @(negedge clk);
    chk("first_count_zero", 64'(count), 64'd0);

    // Back-to-back writes R1..R4.
    for (int i = 1; i <= 4; i++) begin
      step();
      drive(1'b1, TGT_W'(i), DATA_W'(8'h11 * i), 1'b1, 1'b0, 48'h200 + ADDR_W'(i),
            8'h20 + OPC_W'(i));
      expect_wr(TGT_W'(i), DATA_W'(8'h11 * i));
      @(negedge clk);
      chk("b2b_ready", 64'(rb.ow_ready), 64'd1);
    end
    step();
    idle();
    @(negedge clk);
    chk("b2b_pc", 64'(pc), 64'h204);
    wait_empty("b2b_empty");

    // Stream under stall: four accepted, then back-pressure; release with a full queue.
    for (int i = 0; i < 6; i++) begin
      step();
      rf_stall = 1'b1;
      drive(1'b1, TGT_W'(9 + ((i < 4) ? i : 4)), DATA_W'(24'h900 + ((i < 4) ? i : 4)),
            1'b1, 1'b0, 48'h400, 8'h40);
      if (i < 4) expect_wr(TGT_W'(9 + i), DATA_W'(24'h900 + i));
      @(negedge clk);
      chk("stall_ready", 64'(rb.ow_ready), (i < 4) ? 64'd1 : 64'd0);
      chk("stall_count", 64'(count), (i < 4) ? 64'(i) : 64'd4);
    end
    step();
    rf_stall = 1'b0;
    expect_wr(TGT_W'(13), 24'h904);
    @(negedge clk);
    chk("full_accept_ready", 64'(rb.ow_ready), 64'd1);
    chk("full_drain_we", 64'(wr_en), 64'b11);
    step();
    idle();
    @(negedge clk);
    chk("full_count_after", 64'(count), 64'd3);
    wait_empty("stall_empty");

    // Two pending writes to R5: the younger one wins in the shared drain cycle.
    step();
    rf_stall = 1'b1;
    drive(1'b1, TGT_W'(5), 24'h000001, 1'b1, 1'b0, 48'h500, 8'h50);
    @(negedge clk);
    step();
    drive(1'b1, TGT_W'(5), 24'h000002, 1'b1, 1'b0, 48'h501, 8'h51);
    @(negedge clk);
    step();
    idle();
    fwd_addr = TGT_W'(5);
    expect_wr(TGT_W'(5), 24'h000002);
    @(negedge clk);
    chk("yw_count", 64'(count), 64'd2);
    chk("yw_fwd_hit", 64'(fwd_hit), 64'd1);
    chk("yw_fwd_data", 64'(fwd_data), 64'h2);
    fwd_addr = TGT_W'(6);
    #1;
    chk("miss_fwd_hit", 64'(fwd_hit), 64'd0);
    chk("miss_fwd_data", 64'(fwd_data), 64'd0);
    fwd_addr = TGT_W'(5);
    step();
    rf_stall = 1'b0;
    @(negedge clk);
    chk("yw_we", 64'(wr_en), 64'b10);
    chk("yw_drain_fwd_hit", 64'(fwd_hit), 64'd1);
    chk("yw_drain_fwd_data", 64'(fwd_data), 64'h2);
    step();
    @(negedge clk);
    chk("yw_count_zero", 64'(count), 64'd0);
    chk("yw_fwd_gone", 64'(fwd_hit), 64'd0);

    // Trap behind two pending writes.
    step();
    rf_stall = 1'b1;
    drive(1'b1, TGT_W'(7), 24'h000077, 1'b1, 1'b0, 48'h600, 8'h60);
    expect_wr(TGT_W'(7), 24'h000077);
    @(negedge clk);
    step();
    drive(1'b1, TGT_W'(8), 24'h000088, 1'b1, 1'b0, 48'h601, 8'h61);
    expect_wr(TGT_W'(8), 24'h000088);
    @(negedge clk);
    step();
    drive(1'b1, TGT_W'(0), 24'h0, 1'b0, 1'b1, 48'h602, 8'h62);
    @(negedge clk);
    chk("trap_accept_ready", 64'(rb.ow_ready), 64'd1);
    for (int i = 0; i < 2; i++) begin
      step();
      drive(1'b1, TGT_W'(9), 24'h000099, 1'b1, 1'b0, 48'h700, 8'h70);
      @(negedge clk);
      chk("trap_hold_ready", 64'(rb.ow_ready), 64'd0);
      chk("trap_hold_pulse", 64'(trap), 64'd0);
      chk("trap_hold_count", 64'(count), 64'd2);
      chk("trap_hold_pc", 64'(pc), 64'h602);
    end
    step();
    idle();
    rf_stall = 1'b0;
    @(negedge clk);
    chk("trap_drain_we", 64'(wr_en), 64'b11);
    chk("trap_drain_pulse", 64'(trap), 64'd0);
    chk("trap_drain_ready", 64'(rb.ow_ready), 64'd0);
    step();
    @(negedge clk);
    chk("trap_pulse", 64'(trap), 64'd1);
    chk("trap_pulse_count", 64'(count), 64'd0);
    chk("trap_pulse_ready", 64'(rb.ow_ready), 64'd1);
    step();
    @(negedge clk);
    chk("trap_pulse_end", 64'(trap), 64'd0);
    chk("trap_after_ready", 64'(rb.ow_ready), 64'd1);

    // Trap with an empty queue and no write: pulse the cycle after acceptance.
    step();
    drive(1'b1, TGT_W'(0), 24'h0, 1'b0, 1'b1, 48'h800, 8'h80);
    @(negedge clk);
    chk("etrap_ready", 64'(rb.ow_ready), 64'd1);
    step();
    idle();
    @(negedge clk);
    chk("etrap_pulse", 64'(trap), 64'd1);
    chk("etrap_pc", 64'(pc), 64'h800);
    step();
    @(negedge clk);
    chk("etrap_pulse_end", 64'(trap), 64'd0);

    // Reset mid-operation discards pending writes.
    step();
    rf_stall = 1'b1;
    drive(1'b1, TGT_W'(2), 24'h000222, 1'b1, 1'b0, 48'h900, 8'h90);
    @(negedge clk);
    step();
    drive(1'b1, TGT_W'(3), 24'h000333, 1'b1, 1'b0, 48'h901, 8'h91);
    @(negedge clk);
    step();
    idle();
    rst = 1'b1;
    #1;
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_pc", 64'(pc), 64'd0);
    @(negedge clk);
    step();
    rst = 1'b0;
    rf_stall = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_count_after", 64'(count), 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
